// File: rtl/ir_shoot_tx_fifo.sv
// ir_shoot_tx_fifo
//   APB3 slave IR shot transmitter with a frame queue. Each CMD write queues
//   a frame of 1..MAX_BITS bits. Bits go out MSB first. A '0' is SHORT_PULSES
//   carrier periods and a '1' is LONG_PULSES carrier periods. Every burst is
//   followed by GAP_CYCLES cycles of silence. The carrier period (DIV) and the
//   high time (DUTY) can be changed at run time. Each frame keeps the values
//   that were current when it was popped.
//
// Ports
//   PCLK, PRESET     clock, asynchronous active-high reset
//   PSEL, PENABLE,   APB3 slave access
//   PWRITE, PADDR,
//   PWDATA
//   PRDATA           read data, combinational from PADDR
//   PREADY           always 1
//   PSLVERR          1 during a CMD write access while the FIFO is full
//   shooting         modulated IR LED drive, registered
//   tr               one-cycle pulse aligned with a frame's first carrier cycle
//   busy             frame in flight or FIFO non-empty
//
// Registers
//   0x00 CMD      W    [MAX_BITS-1:0] data, [28:24] len
//   0x04 STATUS   R    [0] busy [1] full [2] empty [3] ovf [11:8] count
//                 W1C  [3] ovf
//   0x08 CARRIER  RW   [15:0] div, [31:16] duty
//   0x0C CTRL     W    [0] abort
//
// FSM states
//   state  | meaning
//   IDLE   | nothing in flight, pops the next queued frame when one exists
//   MARK   | carrier burst for the current bit
//   GAP    | silence after a burst, then next bit / next frame / idle

module ir_shoot_tx_fifo #(
  parameter int FIFO_DEPTH   = 4,
  parameter int MAX_BITS     = 16,
  parameter int SHORT_PULSES = 7,
  parameter int LONG_PULSES  = 19,
  parameter int GAP_CYCLES   = 40000,
  parameter int DIV_RST      = 2632,
  parameter int DUTY_RST     = 1974
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [7:0]  PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        shooting,
  output logic        tr,
  output logic        busy
);

  localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W     = PTR_W + 1;
  localparam int IDX_W     = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;
  localparam int ENT_W     = 5 + MAX_BITS;
  localparam int PULSE_MAX = (LONG_PULSES > SHORT_PULSES) ? LONG_PULSES : SHORT_PULSES;
  localparam int P_W       = $clog2(PULSE_MAX + 1);
  localparam int GAP_W     = $clog2(GAP_CYCLES + 1);

  localparam logic [P_W-1:0]   SHORT_M1 = P_W'(SHORT_PULSES - 1);
  localparam logic [P_W-1:0]   LONG_M1  = P_W'(LONG_PULSES - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
  localparam logic [4:0]       LEN_MAX  = 5'(MAX_BITS);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  localparam logic [7:0] ADDR_CMD     = 8'h00;
  localparam logic [7:0] ADDR_STATUS  = 8'h04;
  localparam logic [7:0] ADDR_CARRIER = 8'h08;
  localparam logic [7:0] ADDR_CTRL    = 8'h0C;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MARK = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // APB decode
  // ---------------------------------------------------------------------------
  logic wr_en, cmd_wr, abort, push, ovf_set;
  logic full, empty;

  assign wr_en  = PSEL & PENABLE & PWRITE;
  assign cmd_wr = wr_en && (PADDR == ADDR_CMD);
  assign abort  = wr_en && (PADDR == ADDR_CTRL) && PWDATA[0];
  // Abort has priority: a push in the same cycle is dropped and does not count
  // as an overflow.
  assign push    = cmd_wr && !full && !abort;
  assign ovf_set = cmd_wr && full && !abort;

  assign PREADY  = 1'b1;
  assign PSLVERR = cmd_wr && full;

  // ---------------------------------------------------------------------------
  // Frame FIFO
  // ---------------------------------------------------------------------------
  logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             pop;

  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);

  always_ff @(posedge PCLK) begin
    if (push) mem_q[wr_ptr_q] <= {PWDATA[28:24], PWDATA[MAX_BITS-1:0]};
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (abort) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Head-of-queue entry, decoded for latching on pop.
  logic [ENT_W-1:0]    head;
  logic [4:0]          head_len, len_cl, len_m1;
  logic [MAX_BITS-1:0] head_data;
  logic [IDX_W-1:0]    idx_load;

  assign head      = mem_q[rd_ptr_q];
  assign head_len  = head[ENT_W-1 -: 5];
  assign head_data = head[MAX_BITS-1:0];
  assign len_cl    = (head_len > LEN_MAX) ? LEN_MAX : head_len;
  assign len_m1    = len_cl - 5'd1;
  assign idx_load  = len_m1[IDX_W-1:0];

  // ---------------------------------------------------------------------------
  // Configuration / status registers
  // ---------------------------------------------------------------------------
  logic [15:0] div_q, duty_q, div_eff;
  logic        ovf_q;

  assign div_eff = (div_q == 16'd0) ? 16'd1 : div_q;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      div_q  <= 16'(DIV_RST);
      duty_q <= 16'(DUTY_RST);
      ovf_q  <= 1'b0;
    end else begin
      if (wr_en && (PADDR == ADDR_CARRIER)) begin
        div_q  <= PWDATA[15:0];
        duty_q <= PWDATA[31:16];
      end
      if (ovf_set)
        ovf_q <= 1'b1;
      else if (wr_en && (PADDR == ADDR_STATUS) && PWDATA[3])
        ovf_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------------
  state_t              state_q, state_d;
  logic [MAX_BITS-1:0] data_q;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [15:0]         fdiv_q, fduty_q;
  logic [15:0]         c_q, c_d;
  logic [P_W-1:0]      p_q, p_d, n_m1;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic                first_q, first_d;
  logic                load;
  logic                shoot_q, shoot_d, tr_q, tr_d;

  assign n_m1 = data_q[idx_q] ? LONG_M1 : SHORT_M1;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    c_d     = c_q;
    p_d     = p_q;
    gap_d   = gap_q;
    first_d = first_q;
    pop     = 1'b0;
    load    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          // A zero-length entry is consumed without starting a frame.
          if (len_cl != 5'd0) begin
            load    = 1'b1;
            state_d = S_MARK;
          end
        end
      end
      S_MARK: begin
        first_d = 1'b0;
        if (c_q == fdiv_q - 16'd1) begin
          c_d = 16'd0;
          if (p_q == n_m1) begin
            p_d     = '0;
            gap_d   = GAP_LOAD;
            state_d = S_GAP;
          end else begin
            p_d = p_q + 1'b1;
          end
        end else begin
          c_d = c_q + 16'd1;
        end
      end
      S_GAP: begin
        if (gap_q == '0) begin
          if (idx_q != '0) begin
            idx_d   = idx_q - 1'b1;
            state_d = S_MARK;
          end else if (!empty) begin
            // Chain straight into the next frame with no idle cycle.
            pop = 1'b1;
            if (len_cl != 5'd0) begin
              load    = 1'b1;
              state_d = S_MARK;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      c_d     = 16'd0;
      p_d     = '0;
      idx_d   = idx_load;
      first_d = 1'b1;
    end

    if (abort) begin
      state_d = S_IDLE;
      pop     = 1'b0;
      load    = 1'b0;
      first_d = 1'b0;
    end
  end

  // Outputs are registered from the current state, so the LED lags the FSM by
  // one cycle; an abort forces them low on the abort edge itself.
  assign shoot_d = (state_q == S_MARK) && (c_q < fduty_q) && !abort;
  assign tr_d    = (state_q == S_MARK) && first_q && !abort;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      idx_q   <= '0;
      fdiv_q  <= 16'd1;
      fduty_q <= 16'd0;
      c_q     <= 16'd0;
      p_q     <= '0;
      gap_q   <= '0;
      first_q <= 1'b0;
      shoot_q <= 1'b0;
      tr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      c_q     <= c_d;
      p_q     <= p_d;
      gap_q   <= gap_d;
      first_q <= first_d;
      shoot_q <= shoot_d;
      tr_q    <= tr_d;
      if (load) begin
        data_q  <= head_data;
        fdiv_q  <= div_eff;
        fduty_q <= duty_q;
      end
    end
  end

  assign shooting = shoot_q;
  assign tr       = tr_q;
  assign busy     = (state_q != S_IDLE) || !empty;

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  always_comb begin
    PRDATA = 32'd0;
    unique case (PADDR)
      ADDR_STATUS: begin
        PRDATA[0]    = busy;
        PRDATA[1]    = full;
        PRDATA[2]    = empty;
        PRDATA[3]    = ovf_q;
        PRDATA[11:8] = 4'(count_q);
      end
      ADDR_CARRIER: PRDATA = {duty_q, div_q};
      default:      PRDATA = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_ir_shoot_tx_fifo.sv
module tb_ir_shoot_tx_fifo;

  localparam int SHORT = 2;
  localparam int LONG  = 4;
  localparam int GAP   = 10;
  localparam int DIV0  = 8;
  localparam int DUTY0 = 6;
  localparam int LOGN  = 8192;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        PSEL, PENABLE, PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR, shooting, tr, busy;

  int errors = 0;
  int checks = 0;

  ir_shoot_tx_fifo #(
    .FIFO_DEPTH(4), .MAX_BITS(16), .SHORT_PULSES(SHORT), .LONG_PULSES(LONG),
    .GAP_CYCLES(GAP), .DIV_RST(DIV0), .DUTY_RST(DUTY0)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .shooting(shooting), .tr(tr),
    .busy(busy)
  );

  always #5 PCLK = ~PCLK;

  // Per-cycle trace, sampled mid-cycle; log[cyc] holds the sample after the
  // most recent rising edge.
  int   cyc = 0;
  logic log_sh [0:LOGN-1];
  logic log_tr [0:LOGN-1];
  logic log_bz [0:LOGN-1];

  always @(negedge PCLK) begin
    if (cyc < LOGN) begin
      log_sh[cyc] <= shooting;
      log_tr[cyc] <= tr;
      log_bz[cyc] <= busy;
    end
    cyc <= cyc + 1;
  end

  logic exp_sh[$];
  logic exp_tr[$];

  // Reference waveform for one frame, appended to the expected queues.
  task automatic model_frame(input int len, input int data, input int div, input int duty);
    logic first = 1'b1;
    for (int b = len - 1; b >= 0; b--) begin
      int n = ((data >> b) & 1) ? LONG : SHORT;
      for (int per = 0; per < n; per++) begin
        for (int c = 0; c < div; c++) begin
          exp_sh.push_back(c < duty);
          exp_tr.push_back(first);
          first = 1'b0;
        end
      end
      for (int g = 0; g < GAP; g++) begin
        exp_sh.push_back(1'b0);
        exp_tr.push_back(1'b0);
      end
    end
  endtask

  function automatic int wave_diffs(input int base);
    int n = 0;
    for (int i = 0; i < exp_sh.size(); i++) begin
      if (log_sh[base + i] !== exp_sh[i]) n++;
      if (log_tr[base + i] !== exp_tr[i]) n++;
    end
    return n;
  endfunction

  function automatic int activity(input int base, input int len);
    int n = 0;
    for (int i = 0; i < len; i++) begin
      if (log_sh[base + i] !== 1'b0) n++;
      if (log_tr[base + i] !== 1'b0) n++;
    end
    return n;
  endfunction

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d, output logic err);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1 err = PSLVERR;
    @(posedge PCLK);
    #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
    PADDR = a;
    #1 d = PRDATA;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    checks++;
    if (shooting !== 1'b0 || tr !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got shooting=%b tr=%b busy=%b, expected 0 0 0", shooting, tr, busy);
    end
    apb_read(8'h04, rd);
    checks++;
    if (rd !== 32'h0000_0004) begin
      errors++; $display("FAIL reset_status: got %h expected 00000004", rd);
    end
    apb_read(8'h08, rd);
    checks++;
    if (rd !== 32'h0006_0008) begin
      errors++; $display("FAIL reset_carrier: got %h expected 00060008", rd);
    end
    apb_read(8'h10, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL unmapped_read: got %h expected 00000000", rd);
    end
    checks++;
    if (PREADY !== 1'b1 || PSLVERR !== 1'b0) begin
      errors++; $display("FAIL reset_apb: got pready=%b pslverr=%b expected 1 0", PREADY, PSLVERR);
    end
  endtask

  task automatic test_single_frame();
    logic err;
    int   s, n;
    apb_write(8'h00, 32'h0300_0005, err);
    s = cyc;
    repeat (125) @(posedge PCLK);
    exp_sh.delete(); exp_tr.delete();
    model_frame(3, 5, DIV0, DUTY0);
    checks++;
    if (log_sh[s + 1] !== 1'b0 || log_sh[s + 2] !== 1'b1) begin
      errors++;
      $display("FAIL latency: got k1=%b k2=%b expected 0 1", log_sh[s + 1], log_sh[s + 2]);
    end
    n = wave_diffs(s + 2);
    checks++;
    if (n !== 0) begin
      errors++; $display("FAIL single_wave: got %0d differing samples expected 0", n);
    end
    n = 0;
    for (int k = 0; k < 116; k++) if (log_bz[s + k] !== (k <= 110)) n++;
    checks++;
    if (n !== 0) begin
      errors++; $display("FAIL single_busy: got %0d differing samples expected 0", n);
    end
    n = activity(s + 112, 10) + activity(s, 2);
    checks++;
    if (n !== 0) begin
      errors++; $display("FAIL single_quiet: got %0d active samples outside frame expected 0", n);
    end
  endtask

  task automatic test_overflow();
    logic        err;
    logic [31:0] rd;
    logic [4:0]  errs;
    apb_write(8'h00, 32'h1000_FFFF, err);
    for (int i = 0; i < 5; i++) begin
      apb_write(8'h00, 32'h0100_0000, err);
      errs[i] = err;
    end
    checks++;
    if (errs !== 5'b10000) begin
      errors++; $display("FAIL pslverr: got %b expected 10000", errs);
    end
    apb_read(8'h04, rd);
    checks++;
    if (rd !== 32'h0000_040B) begin
      errors++; $display("FAIL ovf_status: got %h expected 0000040b", rd);
    end
    apb_write(8'h0C, 32'h1, err);
    apb_read(8'h04, rd);
    checks++;
    if (rd !== 32'h0000_000C) begin
      errors++; $display("FAIL abort_keeps_ovf: got %h expected 0000000c", rd);
    end
    apb_write(8'h04, 32'h8, err);
    apb_read(8'h04, rd);
    checks++;
    if (rd !== 32'h0000_0004) begin
      errors++; $display("FAIL ovf_w1c: got %h expected 00000004", rd);
    end
  endtask

  task automatic test_back_to_back();
    logic err;
    int   s, n, t2;
    apb_write(8'h00, 32'h0100_0000, err);
    s = cyc;
    apb_write(8'h00, 32'h0200_0002, err);
    repeat (110) @(posedge PCLK);
    exp_sh.delete(); exp_tr.delete();
    model_frame(1, 0, DIV0, DUTY0);
    model_frame(2, 2, DIV0, DUTY0);
    n = wave_diffs(s + 2);
    checks++;
    if (n !== 0) begin
      errors++; $display("FAIL b2b_wave: got %0d differing samples expected 0", n);
    end
    t2 = -1;
    for (int k = 3; k < 100; k++) if (t2 < 0 && log_tr[s + k] === 1'b1) t2 = k;
    checks++;
    if (t2 !== 28) begin
      errors++; $display("FAIL b2b_second_tr: got cycle %0d expected 28", t2);
    end
    n = 0;
    for (int k = 0; k <= 94; k++) if (log_bz[s + k] !== 1'b1) n++;
    if (log_bz[s + 95] !== 1'b0) n++;
    checks++;
    if (n !== 0) begin
      errors++; $display("FAIL b2b_busy: got %0d differing samples expected 0", n);
    end
  endtask

  task automatic test_carrier_update();
    logic        err;
    logic [31:0] rd;
    int          s, n;
    apb_write(8'h00, 32'h0100_0001, err);
    s = cyc;
    apb_write(8'h00, 32'h0100_0000, err);
    apb_write(8'h08, 32'h0003_0006, err);
    apb_read(8'h08, rd);
    checks++;
    if (rd !== 32'h0003_0006) begin
      errors++; $display("FAIL carrier_readback: got %h expected 00030006", rd);
    end
    repeat (90) @(posedge PCLK);
    exp_sh.delete(); exp_tr.delete();
    model_frame(1, 1, DIV0, DUTY0);
    model_frame(1, 0, 6, 3);
    n = wave_diffs(s + 2) + activity(s + 2 + exp_sh.size(), 10);
    checks++;
    if (n !== 0) begin
      errors++; $display("FAIL carrier_wave: got %0d differing samples expected 0", n);
    end
    apb_write(8'h08, 32'h0006_0008, err);
  endtask

  task automatic test_abort();
    logic        err, prev, seen;
    logic [31:0] rd;
    int          s, n;
    apb_write(8'h00, 32'h0400_000F, err);
    apb_write(8'h00, 32'h0100_0000, err);
    apb_write(8'h00, 32'h0100_0000, err);
    prev = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge PCLK);
      if (prev === 1'b0 && shooting === 1'b1) seen = 1'b1;
      prev = shooting;
    end
    checks++;
    if (seen !== 1'b1) begin
      errors++; $display("FAIL abort_wait: got no carrier rise within 40 cycles expected one");
    end
    apb_write(8'h0C, 32'h1, err);
    checks++;
    if (shooting !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_outputs: got shooting=%b busy=%b expected 0 0", shooting, busy);
    end
    apb_read(8'h04, rd);
    checks++;
    if (rd !== 32'h0000_0004) begin
      errors++; $display("FAIL abort_status: got %h expected 00000004", rd);
    end
    s = cyc;
    repeat (100) @(posedge PCLK);
    n = activity(s, 95);
    checks++;
    if (n !== 0) begin
      errors++; $display("FAIL abort_quiet: got %0d active samples expected 0", n);
    end
  endtask

  task automatic test_len_limits();
    logic        err;
    logic [31:0] rd;
    int          s, n;
    apb_write(8'h00, 32'h0000_0005, err);
    s = cyc;
    repeat (20) @(posedge PCLK);
    n = activity(s, 18);
    checks++;
    if (n !== 0 || log_bz[s + 1] !== 1'b0) begin
      errors++;
      $display("FAIL len0: got %0d active samples busy=%b expected 0 0", n, log_bz[s + 1]);
    end
    apb_read(8'h04, rd);
    checks++;
    if (rd !== 32'h0000_0004) begin
      errors++; $display("FAIL len0_status: got %h expected 00000004", rd);
    end
    apb_write(8'h00, 32'h1F00_0000, err);
    s = cyc;
    repeat (430) @(posedge PCLK);
    exp_sh.delete(); exp_tr.delete();
    model_frame(16, 0, DIV0, DUTY0);
    n = wave_diffs(s + 2) + activity(s + 2 + exp_sh.size(), 8);
    checks++;
    if (n !== 0) begin
      errors++; $display("FAIL len31_wave: got %0d differing samples expected 0", n);
    end
    checks++;
    if (log_bz[s + 416] !== 1'b1 || log_bz[s + 417] !== 1'b0) begin
      errors++;
      $display("FAIL len31_busy: got %b%b expected 10", log_bz[s + 416], log_bz[s + 417]);
    end
  endtask

  task automatic test_reset_midframe();
    logic        err, seen;
    logic [31:0] rd;
    apb_write(8'h00, 32'h0300_0007, err);
    apb_write(8'h00, 32'h0100_0000, err);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge PCLK);
      if (shooting === 1'b1) seen = 1'b1;
    end
    #2 PRESET = 1'b1;
    #1;
    checks++;
    if (seen !== 1'b1 || shooting !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got seen=%b shooting=%b busy=%b expected 1 0 0", seen, shooting, busy);
    end
    @(negedge PCLK);
    PRESET = 1'b0;
    apb_read(8'h04, rd);
    checks++;
    if (rd !== 32'h0000_0004) begin
      errors++; $display("FAIL async_reset_status: got %h expected 00000004", rd);
    end
  endtask

  initial begin
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = 8'h00; PWDATA = 32'h0;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    PRESET = 1'b0;
    @(posedge PCLK);
    #1;
    test_reset();
    test_single_frame();
    test_overflow();
    test_back_to_back();
    test_carrier_update();
    test_abort();
    test_len_limits();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
